// File: rtl/axis_moving_sum_if.sv
// AXI-Stream data/valid/ready bundle shared by the sample inputs and the sum output of axis_moving_sum.
interface axis_moving_sum_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_moving_sum.sv
// Boxcar moving sum over the last WINDOW samples, joining the live stream with its WINDOW-delayed copy.
// Optional build macro MOVING_SUM_AVG_EN: output the average (sum >>> clog2(WINDOW)) instead of the sum.
module axis_moving_sum #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int SUM_WIDTH        = 32,
    parameter int WINDOW           = 32
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    axis_moving_sum_if.slave  s_axis,
    axis_moving_sum_if.slave  d_axis,
    axis_moving_sum_if.master m_axis,
    output logic filled
);
    localparam int CNT_WIDTH = $clog2(WINDOW + 1);
    localparam int SHIFT     = $clog2(WINDOW);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(WINDOW);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW - 1);

    if (WINDOW < 2) begin : g_bad_window
        $error("axis_moving_sum: WINDOW must be at least 2");
    end
    if (SUM_WIDTH < AXIS_TDATA_WIDTH + SHIFT) begin : g_bad_width
        $error("axis_moving_sum: SUM_WIDTH too small for WINDOW samples");
    end
`ifdef MOVING_SUM_AVG_EN
    if ((WINDOW & (WINDOW - 1)) != 0) begin : g_bad_avg
        $error("axis_moving_sum: averaging needs a power-of-two WINDOW");
    end
`endif

    logic signed [AXIS_TDATA_WIDTH-1:0] s_sample;
    logic signed [AXIS_TDATA_WIDTH-1:0] d_sample;
    logic signed [SUM_WIDTH-1:0]        s_ext;
    logic signed [SUM_WIDTH-1:0]        d_ext;
    logic signed [SUM_WIDTH-1:0]        sum_q;
    logic signed [SUM_WIDTH-1:0]        sum_next;
    logic signed [SUM_WIDTH-1:0]        out_value;
    logic signed [SUM_WIDTH-1:0]        out_q;
    logic [CNT_WIDTH-1:0]               cnt_q;
    logic                               valid_q;
    logic                               accept;

    assign s_sample = s_axis.tdata;
    assign d_sample = d_axis.tdata;

    // Both inputs are consumed together; ready never depends on our own valid being raised this cycle.
    assign accept        = s_axis.tvalid & d_axis.tvalid & (~valid_q | m_axis.tready);
    assign s_axis.tready = accept;
    assign d_axis.tready = accept;

    assign filled = (cnt_q == CNT_FULL);

    // Delay-line output is garbage until it has been primed with WINDOW samples, so it is ignored until then.
    always_comb begin
        s_ext    = SUM_WIDTH'(s_sample);
        d_ext    = filled ? SUM_WIDTH'(d_sample) : '0;
        sum_next = sum_q + s_ext - d_ext;
`ifdef MOVING_SUM_AVG_EN
        out_value = sum_next >>> SHIFT;
`else
        out_value = sum_next;
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset || clear) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                sum_q <= sum_next;
                if (!filled) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end
            // Warm-up sums stay internal; only full-window results reach the output register.
            if (accept && (cnt_q >= CNT_LAST)) begin
                out_q   <= out_value;
                valid_q <= 1'b1;
            end else if (m_axis.tready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = out_q;
    assign m_axis.tvalid = valid_q;
endmodule

// File: tb/tb_axis_moving_sum.sv
// Scoreboard bench for axis_moving_sum: WINDOW=4 main instance plus a WINDOW=32 instance for the wide-range case.
// Builds with or without MOVING_SUM_AVG_EN; expected values follow the same switch.
module tb_axis_moving_sum;
    localparam int W     = 16;
    localparam int SW    = 32;
    localparam int WIN   = 4;
    localparam int WIN_B = 32;
`ifdef MOVING_SUM_AVG_EN
    localparam int SH_A = 2;
    localparam int SH_B = 5;
`else
    localparam int SH_A = 0;
    localparam int SH_B = 0;
`endif

    logic aclk = 1'b0;
    logic areset;
    logic clear;
    logic filled;
    logic filled_b;

    axis_moving_sum_if #(.WIDTH(W))  s_if ();
    axis_moving_sum_if #(.WIDTH(W))  d_if ();
    axis_moving_sum_if #(.WIDTH(SW)) m_if ();
    axis_moving_sum_if #(.WIDTH(W))  s_b ();
    axis_moving_sum_if #(.WIDTH(W))  d_b ();
    axis_moving_sum_if #(.WIDTH(SW)) m_b ();

    axis_moving_sum #(.AXIS_TDATA_WIDTH(W), .SUM_WIDTH(SW), .WINDOW(WIN)) dut (
        .aclk(aclk), .areset(areset), .clear(clear),
        .s_axis(s_if), .d_axis(d_if), .m_axis(m_if), .filled(filled)
    );

    axis_moving_sum #(.AXIS_TDATA_WIDTH(W), .SUM_WIDTH(SW), .WINDOW(WIN_B)) dut_b (
        .aclk(aclk), .areset(areset), .clear(clear),
        .s_axis(s_b), .d_axis(d_b), .m_axis(m_b), .filled(filled_b)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int hist[$];
    int sb[$];
    int got[$];
    bit mv_m   = 1'b0;
    bit mon_en = 1'b0;
    int model_sum;
    int exp_val;

    function automatic int avg_of(input int v, input int sh);
        return v >>> sh;
    endfunction

    // Reference model: window kept as an explicit list of accepted samples, summed from scratch.
    always @(posedge aclk) begin
        if (areset || clear) begin
            hist.delete();
            sb.delete();
            mv_m = 1'b0;
        end else if (s_if.tvalid && d_if.tvalid && (!mv_m || m_if.tready)) begin
            hist.push_back(int'($signed(s_if.tdata)));
            if (hist.size() > WIN) void'(hist.pop_front());
            if (hist.size() == WIN) begin
                model_sum = 0;
                foreach (hist[i]) model_sum += hist[i];
                sb.push_back(avg_of(model_sum, SH_A));
                mv_m = 1'b1;
            end else if (mv_m && m_if.tready) begin
                mv_m = 1'b0;
            end
        end else if (mv_m && m_if.tready) begin
            mv_m = 1'b0;
        end
    end

    // Output monitor: handshake state every cycle, data popped from the scoreboard on each transfer.
    always @(negedge aclk) begin
        if (mon_en) begin
            checks++;
            if (m_if.tvalid !== mv_m) begin
                failures++;
                $display("[TB] FAIL m_tvalid: got %b expected %b", m_if.tvalid, mv_m);
            end
            checks++;
            if (filled !== (hist.size() == WIN)) begin
                failures++;
                $display("[TB] FAIL filled: got %b expected %b", filled, hist.size() == WIN);
            end
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                checks++;
                got.push_back(int'($signed(m_if.tdata)));
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL m_tdata_extra: got %0d expected no word", $signed(m_if.tdata));
                end else begin
                    exp_val = sb.pop_front();
                    if (m_if.tdata !== SW'(exp_val)) begin
                        failures++;
                        $display("[TB] FAIL m_tdata: got %0d expected %0d", $signed(m_if.tdata), exp_val);
                    end
                end
            end
        end
    end

    // One input beat, driven just after the rising edge; d carries x[n-WIN] once the model window is full.
    task automatic step(input bit sv, input int x, input bit dv, input bit mr);
        @(posedge aclk);
        #1;
        s_if.tvalid = sv;
        s_if.tdata  = W'(x);
        d_if.tvalid = dv;
        d_if.tdata  = (hist.size() == WIN) ? W'(hist[0]) : W'($urandom);
        m_if.tready = mr;
    endtask

    task automatic pulse_reset();
        @(posedge aclk);
        #1;
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        d_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);
        @(negedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        clear  = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = 16'h1234;
        d_if.tvalid = 1'b1; d_if.tdata = 16'h4321;
        m_if.tready = 1'b1;
        s_b.tvalid = 1'b0; s_b.tdata = '0;
        d_b.tvalid = 1'b0; d_b.tdata = '0;
        m_b.tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0) begin
            failures++;
            $display("[TB] FAIL reset_out: got valid=%b data=%0d expected valid=0 data=0", m_if.tvalid, m_if.tdata);
        end
        checks++;
        if (filled !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_filled: got %b expected 0", filled);
        end
        checks++;
        if (s_if.tready !== 1'b1 || d_if.tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready_both: got s=%b d=%b expected 1 1", s_if.tready, d_if.tready);
        end
        d_if.tvalid = 1'b0;
        #1;
        checks++;
        if (s_if.tready !== 1'b0 || d_if.tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_one: got s=%b d=%b expected 0 0", s_if.tready, d_if.tready);
        end
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_constant();
        pulse_reset();
        got.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 5, 1'b1, 1'b1);
        drain();
        checks++;
        if (got.size() != 7) begin
            failures++;
            $display("[TB] FAIL const_count: got %0d expected 7", got.size());
        end
        foreach (got[i]) begin
            checks++;
            if (got[i] != avg_of(20, SH_A)) begin
                failures++;
                $display("[TB] FAIL const_value[%0d]: got %0d expected %0d", i, got[i], avg_of(20, SH_A));
            end
        end
    endtask

    task automatic test_ramp();
        int exp_ramp[7];
        exp_ramp = '{10, 14, 18, 22, 26, 30, 34};
        pulse_reset();
        got.delete();
        for (int x = 1; x <= 10; x++) step(1'b1, x, 1'b1, 1'b1);
        drain();
        checks++;
        if (got.size() != 7) begin
            failures++;
            $display("[TB] FAIL ramp_count: got %0d expected 7", got.size());
        end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] != avg_of(exp_ramp[i], SH_A)) begin
                failures++;
                $display("[TB] FAIL ramp_value[%0d]: got %0d expected %0d", i, got[i], avg_of(exp_ramp[i], SH_A));
            end
        end
    endtask

    task automatic test_wide_range();
        for (int i = 0; i < 40; i++) begin
            @(posedge aclk);
            #1;
            s_b.tvalid = 1'b1;
            s_b.tdata  = 16'h8000;
            d_b.tvalid = 1'b1;
            d_b.tdata  = (i >= WIN_B) ? 16'h8000 : W'($urandom);
            @(negedge aclk);
            checks++;
            if (m_b.tvalid !== (i >= WIN_B)) begin
                failures++;
                $display("[TB] FAIL wide_valid[%0d]: got %b expected %b", i, m_b.tvalid, i >= WIN_B);
            end
            if (i >= WIN_B) begin
                checks++;
                if (m_b.tdata !== SW'(avg_of(-1048576, SH_B))) begin
                    failures++;
                    $display("[TB] FAIL wide_value[%0d]: got %0d expected %0d", i, $signed(m_b.tdata),
                             avg_of(-1048576, SH_B));
                end
            end
        end
        checks++;
        if (filled_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wide_filled: got %b expected 1", filled_b);
        end
        s_b.tvalid = 1'b0;
        d_b.tvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        pulse_reset();
        got.delete();
        for (int i = 0; i < 6; i++) step(1'b1, $urandom_range(2000) - 1000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom_range(2000) - 1000, 1'b1, 1'b0);
            @(negedge aclk);
            checks++;
            if (s_if.tready !== 1'b0 || d_if.tready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_ready[%0d]: got s=%b d=%b expected 0 0", i, s_if.tready, d_if.tready);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL stall_data[%0d]: got %0d expected a pending word", i, $signed(m_if.tdata));
            end else if (m_if.tdata !== SW'(sb[0])) begin
                failures++;
                $display("[TB] FAIL stall_data[%0d]: got %0d expected %0d", i, $signed(m_if.tdata), sb[0]);
            end
        end
        for (int i = 0; i < 6; i++) step(1'b1, $urandom_range(2000) - 1000, 1'b1, 1'b1);
        drain();
        checks++;
        if (got.size() != 9) begin
            failures++;
            $display("[TB] FAIL stall_count: got %0d expected 9", got.size());
        end
    endtask

    task automatic test_join_and_clear();
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 100 + i, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, -50, 1'b0, 1'b1);
            @(negedge aclk);
            checks++;
            if (s_if.tready !== 1'b0 || d_if.tready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL join_ready[%0d]: got s=%b d=%b expected 0 0", i, s_if.tready, d_if.tready);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, -7 * i, 1'b1, 1'b1);
        step(1'b1, 777, 1'b1, 1'b0);
        clear = 1'b1;
        step(1'b0, 0, 1'b0, 1'b1);
        clear = 1'b0;
        @(negedge aclk);
        checks++;
        if (m_if.tvalid !== 1'b0 || filled !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_state: got valid=%b filled=%b expected 0 0", m_if.tvalid, filled);
        end
        got.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 7, 1'b1, 1'b1);
        drain();
        checks++;
        if (got.size() != 3 || got[0] != avg_of(28, SH_A)) begin
            failures++;
            $display("[TB] FAIL clear_restart: got count=%0d first=%0d expected count=3 first=%0d",
                     got.size(), (got.size() > 0) ? got[0] : 0, avg_of(28, SH_A));
        end
    endtask

    task automatic test_average();
        int ones[4];
        ones = '{1, 1, 1, 2};
        pulse_reset();
        got.delete();
        for (int i = 0; i < 4; i++) step(1'b1, -3, 1'b1, 1'b1);
        drain();
        checks++;
        if (got.size() != 1 || got[0] != avg_of(-12, SH_A)) begin
            failures++;
            $display("[TB] FAIL avg_neg: got count=%0d value=%0d expected count=1 value=%0d",
                     got.size(), (got.size() > 0) ? got[0] : 0, avg_of(-12, SH_A));
        end
        pulse_reset();
        got.delete();
        for (int i = 0; i < 4; i++) step(1'b1, ones[i], 1'b1, 1'b1);
        drain();
        checks++;
        if (got.size() != 1 || got[0] != avg_of(5, SH_A)) begin
            failures++;
            $display("[TB] FAIL avg_trunc: got count=%0d value=%0d expected count=1 value=%0d",
                     got.size(), (got.size() > 0) ? got[0] : 0, avg_of(5, SH_A));
        end
    endtask

    task automatic test_drained();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_left: got %0d words expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_wide_range();
        test_backpressure();
        test_join_and_clear();
        test_average();
        test_drained();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
